// File: rtl/vga_timing_pkg.sv
// VGA timing constants shared by the generator and its users.
// Holds the 640x480@60 and 800x600@72 segment sets and the 11-bit count type.
package vga_timing_pkg;
   typedef logic [10:0] count_t;

   localparam int VGA640_H_SYNC = 96;
   localparam int VGA640_H_BP   = 48;
   localparam int VGA640_H_ACT  = 640;
   localparam int VGA640_H_FP   = 16;
   localparam int VGA640_V_SYNC = 2;
   localparam int VGA640_V_BP   = 29;
   localparam int VGA640_V_ACT  = 480;
   localparam int VGA640_V_FP   = 10;

   localparam int SVGA800_H_SYNC = 120;
   localparam int SVGA800_H_BP   = 64;
   localparam int SVGA800_H_ACT  = 800;
   localparam int SVGA800_H_FP   = 56;
   localparam int SVGA800_V_SYNC = 6;
   localparam int SVGA800_V_BP   = 23;
   localparam int SVGA800_V_ACT  = 600;
   localparam int SVGA800_V_FP   = 37;

   // True when lo <= cnt < lo+len.
   function automatic logic in_span(input count_t cnt, input int lo, input int len);
      return (cnt >= count_t'(lo)) && (cnt < count_t'(lo + len));
   endfunction
endpackage

// File: rtl/timing_axis_counter.sv
// Wrapping 0..LEN-1 counter for one raster axis.
// The wrap strobe is combinational so the next axis can step on the same edge.
module timing_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int LEN = 800
) (
   input  logic   clk,
   input  logic   resetn,
   input  logic   en,
   output count_t count,
   output logic   wrap
);
   assign wrap = en && (count == count_t'(LEN - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         count <= '0;
      else if (wrap)
         count <= '0;
      else if (en)
         count <= count + 11'd1;
   end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, H/V counters, addresses for an external
// colour lookup, and sync/DE delayed to line up with the returned colour.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int H_ACT    = VGA640_H_ACT,
   parameter int H_FP     = VGA640_H_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter int V_ACT    = VGA640_V_ACT,
   parameter int V_FP     = VGA640_V_FP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_DLY = 1,
   parameter int COL_W    = 12
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [COL_W-1:0] colour_in,
   output logic [COL_W-1:0] colour_out,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic [9:0]       addrh,
   output logic [8:0]       addrv,
   output logic             addr_valid,
   output logic             pix_tick,
   output logic             line_start,
   output logic             frame_start,
   output logic             vblank
);
   localparam int H_TOT   = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT   = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int H_START = H_SYNC + H_BP;
   localparam int V_START = V_SYNC + V_BP;
   localparam int V_END   = V_START + V_ACT;
   localparam int SR_W    = PIPE_DLY + 1;

   if (H_TOT > 2047) begin : g_bad_htot
      $error("vga_timing_gen: H_TOT exceeds 2047");
   end
   if (V_TOT > 1023) begin : g_bad_vtot
      $error("vga_timing_gen: V_TOT exceeds 1023");
   end
   if (H_ACT > 1024 || V_ACT > 512) begin : g_bad_act
      $error("vga_timing_gen: active area exceeds address width");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16 || PIPE_DLY < 0 || PIPE_DLY > 3) begin : g_bad_range
      $error("vga_timing_gen: CLK_DIV or PIPE_DLY out of range");
   end

   count_t           hcount;
   count_t           vcount;
   logic             h_wrap;
   logic             v_wrap;
   logic [3:0]       div_cnt;
   logic             tick;
   logic             in_act;
   logic             hs_raw;
   logic             vs_raw;
   logic             vb_flag;
   logic [SR_W-1:0]  sr_hs;
   logic [SR_W-1:0]  sr_vs;
   logic [SR_W-1:0]  sr_de;

   assign tick = (div_cnt == 4'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt  <= '0;
         pix_tick <= 1'b0;
      end else begin
         pix_tick <= tick;
         div_cnt  <= tick ? 4'd0 : div_cnt + 4'd1;
      end
   end

   timing_axis_counter #(.LEN(H_TOT)) u_hcnt (
      .clk    (clk),
      .resetn (resetn),
      .en     (tick),
      .count  (hcount),
      .wrap   (h_wrap)
   );

   timing_axis_counter #(.LEN(V_TOT)) u_vcnt (
      .clk    (clk),
      .resetn (resetn),
      .en     (h_wrap),
      .count  (vcount),
      .wrap   (v_wrap)
   );

   assign in_act = in_span(hcount, H_START, H_ACT) && in_span(vcount, V_START, V_ACT);
   assign hs_raw = (hcount < count_t'(H_SYNC));
   assign vs_raw = (vcount < count_t'(V_SYNC));

   // Mirrors vcount >= V_END: set entering the first blanking line, cleared by the frame wrap.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         vb_flag <= 1'b0;
      else if (v_wrap)
         vb_flag <= 1'b0;
      else if (h_wrap && (vcount == count_t'(V_END - 1)))
         vb_flag <= 1'b1;
   end

   // Stage 0 is registered alongside the address; stages 1..PIPE_DLY cover the lookup latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sr_hs <= '0;
         sr_vs <= '0;
         sr_de <= '0;
      end else if (tick) begin
         sr_hs <= SR_W'({sr_hs, hs_raw});
         sr_vs <= SR_W'({sr_vs, vs_raw});
         sr_de <= SR_W'({sr_de, in_act});
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addrh       <= '0;
         addrv       <= '0;
         addr_valid  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         vblank      <= 1'b0;
         hs          <= !HS_POL;
         vs          <= !VS_POL;
         de          <= 1'b0;
         colour_out  <= '0;
      end else if (tick) begin
         addr_valid  <= in_act;
         addrh       <= in_act ? 10'(hcount - count_t'(H_START)) : 10'd0;
         addrv       <= in_act ? 9'(vcount - count_t'(V_START)) : 9'd0;
         line_start  <= (hcount == '0);
         frame_start <= (hcount == '0) && (vcount == '0);
         vblank      <= vb_flag;
         hs          <= sr_hs[PIPE_DLY] ? HS_POL : !HS_POL;
         vs          <= sr_vs[PIPE_DLY] ? VS_POL : !VS_POL;
         de          <= sr_de[PIPE_DLY];
         colour_out  <= sr_de[PIPE_DLY] ? colour_in : '0;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a fast inverted-polarity
// variant, and a small raster with a 2-tick colour lookup model.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic        rst_def = 1'b0;
   logic        rst_fast = 1'b0;
   logic        rst_pipe = 1'b0;

   logic [11:0] d_cin = 12'hF00;
   logic [11:0] d_col;
   logic        d_hs, d_vs, d_de, d_av, d_pix, d_ls, d_fs, d_vb;
   logic [9:0]  d_ah;
   logic [8:0]  d_avr;

   logic [11:0] f_cin = 12'hF00;
   logic [11:0] f_col;
   logic        f_hs, f_vs, f_de, f_av, f_pix, f_ls, f_fs, f_vb;
   logic [9:0]  f_ah;
   logic [8:0]  f_avr;

   logic [11:0] p_cin = 12'h000;
   logic [11:0] p_col;
   logic        p_hs, p_vs, p_de, p_av, p_pix, p_ls, p_fs, p_vb;
   logic [9:0]  p_ah;
   logic [8:0]  p_avr;

   vga_timing_gen u_def (
      .clk(clk), .resetn(rst_def), .colour_in(d_cin), .colour_out(d_col),
      .hs(d_hs), .vs(d_vs), .de(d_de), .addrh(d_ah), .addrv(d_avr),
      .addr_valid(d_av), .pix_tick(d_pix), .line_start(d_ls),
      .frame_start(d_fs), .vblank(d_vb)
   );

   vga_timing_gen #(.CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)) u_fast (
      .clk(clk), .resetn(rst_fast), .colour_in(f_cin), .colour_out(f_col),
      .hs(f_hs), .vs(f_vs), .de(f_de), .addrh(f_ah), .addrv(f_avr),
      .addr_valid(f_av), .pix_tick(f_pix), .line_start(f_ls),
      .frame_start(f_fs), .vblank(f_vb)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2),
      .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(1), .PIPE_DLY(2)
   ) u_pipe (
      .clk(clk), .resetn(rst_pipe), .colour_in(p_cin), .colour_out(p_col),
      .hs(p_hs), .vs(p_vs), .de(p_de), .addrh(p_ah), .addrv(p_avr),
      .addr_valid(p_av), .pix_tick(p_pix), .line_start(p_ls),
      .frame_start(p_fs), .vblank(p_vb)
   );

   task automatic test_reset();
      int n;
      rst_def = 1'b0; rst_fast = 1'b0; rst_pipe = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (d_hs !== 1'b1 || d_vs !== 1'b1) begin
         failures++; $display("FAIL reset_sync_def hs=%b vs=%b required 1 1", d_hs, d_vs);
      end
      checks++;
      if (f_hs !== 1'b0 || f_vs !== 1'b0) begin
         failures++; $display("FAIL reset_sync_fast hs=%b vs=%b required 0 0", f_hs, f_vs);
      end
      checks++;
      if ({d_pix, d_de, d_av, d_fs, d_ls, d_vb} !== 6'b0) begin
         failures++; $display("FAIL reset_flags_def got %b required 000000", {d_pix, d_de, d_av, d_fs, d_ls, d_vb});
      end
      checks++;
      if (d_ah !== 10'd0 || d_avr !== 9'd0 || d_col !== 12'd0) begin
         failures++; $display("FAIL reset_data_def addrh=%0d addrv=%0d col=%h required 0 0 000", d_ah, d_avr, d_col);
      end
      checks++;
      if (f_pix !== 1'b0 || f_fs !== 1'b0) begin
         failures++; $display("FAIL reset_pix_fast pix=%b fs=%b required 0 0", f_pix, f_fs);
      end
      @(posedge clk); #2;
      rst_def = 1'b1;
      n = -1;
      for (int i = 1; i <= 12 && n < 0; i++) begin
         @(posedge clk); #1;
         if (d_fs === 1'b1) n = i;
      end
      checks++;
      if (n != 4) begin
         failures++; $display("FAIL first_frame_start_clks got %0d required 4", n);
      end
      checks++;
      if (d_pix !== 1'b1 || d_ls !== 1'b1) begin
         failures++; $display("FAIL first_tick_pulses pix=%b ls=%b required 1 1", d_pix, d_ls);
      end
      @(posedge clk); #1;
      checks++;
      if (d_pix !== 1'b0 || d_fs !== 1'b1) begin
         failures++; $display("FAIL between_ticks pix=%b fs=%b required 0 1", d_pix, d_fs);
      end
   endtask

   task automatic test_default_sync();
      int f1 = -1, r1 = -1, f2 = -1, vf = -1, vr = -1;
      logic ph, pv;
      rst_def = 1'b0;
      @(posedge clk); #2;
      rst_def = 1'b1;
      ph = d_hs; pv = d_vs;
      for (int i = 1; i <= 7000 && (f2 < 0 || vr < 0); i++) begin
         @(posedge clk); #1;
         if (ph && !d_hs) begin
            if (f1 < 0) f1 = i;
            else if (r1 >= 0 && f2 < 0) f2 = i;
         end
         if (!ph && d_hs && f1 >= 0 && r1 < 0) r1 = i;
         if (pv && !d_vs && vf < 0) vf = i;
         if (!pv && d_vs && vf >= 0 && vr < 0) vr = i;
         ph = d_hs; pv = d_vs;
      end
      checks++;
      if (r1 - f1 != 384) begin
         failures++; $display("FAIL hs_low_clks got %0d required 384", r1 - f1);
      end
      checks++;
      if (f2 - f1 != 3200) begin
         failures++; $display("FAIL hs_period_clks got %0d required 3200", f2 - f1);
      end
      checks++;
      if (vr - vf != 6400) begin
         failures++; $display("FAIL vs_low_clks got %0d required 6400", vr - vf);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      rst_def = 1'b0;
      @(posedge clk); #2;
      rst_def = 1'b1;
      repeat (1204) @(posedge clk);
      #3;
      checks++;
      if (d_vs !== 1'b0 || d_hs !== 1'b1) begin
         failures++; $display("FAIL pre_pulse_sync vs=%b hs=%b required 0 1", d_vs, d_hs);
      end
      rst_def = 1'b0;
      #1;
      checks++;
      if (d_vs !== 1'b1 || d_hs !== 1'b1) begin
         failures++; $display("FAIL pulse_sync vs=%b hs=%b required 1 1", d_vs, d_hs);
      end
      checks++;
      if ({d_pix, d_de, d_av, d_fs, d_ls, d_vb} !== 6'b0 || d_col !== 12'd0) begin
         failures++; $display("FAIL pulse_outputs flags=%b col=%h required 000000 000", {d_pix, d_de, d_av, d_fs, d_ls, d_vb}, d_col);
      end
      #4;
      rst_def = 1'b1;
      n = -1;
      for (int i = 1; i <= 12 && n < 0; i++) begin
         @(posedge clk); #1;
         if (d_fs === 1'b1) n = i;
      end
      checks++;
      if (n != 4) begin
         failures++; $display("FAIL post_pulse_frame_start got %0d required 4", n);
      end
   endtask

   task automatic test_fast_boundary();
      int pz = 0, hs_hi = 0, dec = 0, cv = 0, ru1 = -1, ru2 = -1;
      logic ph;
      rst_fast = 1'b0;
      @(posedge clk); #2;
      rst_fast = 1'b1;
      ph = f_hs;
      for (int off = 0; off <= 25750; off++) begin
         @(posedge clk); #1;
         if (off == 0) begin
            checks++;
            if (f_fs !== 1'b1 || f_pix !== 1'b1) begin
               failures++; $display("FAIL fast_first_tick fs=%b pix=%b required 1 1", f_fs, f_pix);
            end
         end
         if (f_pix !== 1'b1) pz++;
         if (off >= 800 && off < 1600 && f_hs === 1'b1) hs_hi++;
         if (!ph && f_hs) begin
            if (ru1 < 0) ru1 = off;
            else if (ru2 < 0) ru2 = off;
         end
         ph = f_hs;
         if (off >= 24800 && off < 25600 && f_de === 1'b1) dec++;
         if (f_de === 1'b1 ? (f_col !== 12'hF00) : (f_col !== 12'h000)) cv++;
         case (off)
            24943: begin
               checks++;
               if (f_av !== 1'b0 || f_ah !== 10'd0) begin
                  failures++; $display("FAIL edge_h143 valid=%b addrh=%0d required 0 0", f_av, f_ah);
               end
            end
            24944: begin
               checks++;
               if (f_av !== 1'b1 || f_ah !== 10'd0 || f_avr !== 9'd0) begin
                  failures++; $display("FAIL edge_h144 valid=%b addrh=%0d addrv=%0d required 1 0 0", f_av, f_ah, f_avr);
               end
            end
            25583: begin
               checks++;
               if (f_av !== 1'b1 || f_ah !== 10'd639) begin
                  failures++; $display("FAIL edge_h783 valid=%b addrh=%0d required 1 639", f_av, f_ah);
               end
            end
            25584: begin
               checks++;
               if (f_av !== 1'b0 || f_ah !== 10'd0) begin
                  failures++; $display("FAIL edge_h784 valid=%b addrh=%0d required 0 0", f_av, f_ah);
               end
            end
            25744: begin
               checks++;
               if (f_av !== 1'b1 || f_avr !== 9'd1) begin
                  failures++; $display("FAIL second_line valid=%b addrv=%0d required 1 1", f_av, f_avr);
               end
            end
            default: ;
         endcase
      end
      checks++;
      if (pz != 0) begin
         failures++; $display("FAIL pix_tick_constant low_clks=%0d required 0", pz);
      end
      checks++;
      if (hs_hi != 96) begin
         failures++; $display("FAIL fast_hs_high got %0d required 96", hs_hi);
      end
      checks++;
      if (ru2 - ru1 != 800) begin
         failures++; $display("FAIL fast_hs_period got %0d required 800", ru2 - ru1);
      end
      checks++;
      if (dec != 640) begin
         failures++; $display("FAIL de_per_line got %0d required 640", dec);
      end
      checks++;
      if (cv != 0) begin
         failures++; $display("FAIL colour_gating bad_clks=%0d required 0", cv);
      end
   endtask

   task automatic test_pipe_colour();
      logic [11:0] m0 = '0, m1 = '0, m2 = '0;
      logic [11:0] first_col = 12'hFFF, last_col = 12'hFFF;
      logic [11:0] expv;
      logic [5:0]  ex = '0, ey = '0;
      int tk = 0, de_cnt = 0, rises = 0, vb = 0, ls = 0, fs = 0, err = 0, err0 = 0;
      logic pde = 1'b0;
      rst_pipe = 1'b0;
      p_cin = '0;
      @(posedge clk); #2;
      rst_pipe = 1'b1;
      for (int i = 0; i < 1000 && tk < 374; i++) begin
         @(posedge clk); #1;
         if (p_pix === 1'b1) begin
            m2 = m1; m1 = m0; m0 = {p_ah[5:0], p_avr[5:0]};
            p_cin = m2;
            if (tk == 0) begin
               checks++;
               if (p_fs !== 1'b1) begin
                  failures++; $display("FAIL pipe_first_frame_start got %b required 1", p_fs);
               end
            end
            if (p_de === 1'b1) begin
               expv = {ex, ey};
               if (p_col !== expv) begin
                  err++;
                  if (err <= 3) $display("FAIL pixel_colour tick=%0d got %h required %h", tk, p_col, expv);
               end
               if (de_cnt == 0) first_col = p_col;
               if (de_cnt == 47) last_col = p_col;
               de_cnt++;
               if (ex == 6'd7) begin
                  ex = '0;
                  ey = (ey == 6'd5) ? 6'd0 : ey + 6'd1;
               end else begin
                  ex = ex + 6'd1;
               end
               if (!pde) rises++;
            end else if (p_col !== 12'h000) begin
               err0++;
            end
            pde = p_de;
            if (p_vb === 1'b1) vb++;
            if (p_ls === 1'b1) ls++;
            if (p_fs === 1'b1) fs++;
            tk++;
         end
      end
      checks++;
      if (err != 0) begin
         failures++; $display("FAIL pixel_colour_total got %0d mismatching required 0", err);
      end
      checks++;
      if (err0 != 0) begin
         failures++; $display("FAIL pipe_blank_colour got %0d nonzero required 0", err0);
      end
      checks++;
      if (first_col !== 12'h000 || last_col !== 12'h1C5) begin
         failures++; $display("FAIL first_last_pixel got %h %h required 000 1c5", first_col, last_col);
      end
      checks++;
      if (de_cnt != 96 || rises != 12) begin
         failures++; $display("FAIL pipe_de_counts ticks=%0d lines=%0d required 96 12", de_cnt, rises);
      end
      checks++;
      if (vb != 34) begin
         failures++; $display("FAIL pipe_vblank_ticks got %0d required 34", vb);
      end
      checks++;
      if (ls != 22 || fs != 2) begin
         failures++; $display("FAIL pipe_starts line=%0d frame=%0d required 22 2", ls, fs);
      end
   endtask

   initial begin
      test_reset();
      test_default_sync();
      test_mid_reset();
      test_fast_boundary();
      test_pipe_colour();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
